// File: rtl/sma_stream.sv
// rtl/sma_stream.sv - streaming simple-moving-average filter, valid/ready flow control
// Running sum over a circular delay line; one registered output stage.
module sma_stream #(
    parameter int DATA_W    = 16,
    parameter int LOG2_N    = 2,
    parameter int FILL_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_full
);

    localparam int N      = 1 << LOG2_N;
    localparam int ACC_W  = DATA_W + LOG2_N;
    localparam int PTR_W  = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int FILL_W = LOG2_N + 1;

    localparam logic [PTR_W-1:0]        WP_LAST   = PTR_W'(N - 1);
    localparam logic [FILL_W-1:0]       FILL_MAX  = FILL_W'(N);
    localparam logic [FILL_W-1:0]       FILL_LAST = FILL_W'(N - 1);
    localparam logic signed [ACC_W-1:0] RND       = ACC_W'(N - 1);

    logic [DATA_W-1:0]        dline_q [N];
    logic [PTR_W-1:0]         wp_q, wp_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;

    logic                     accept;
    logic signed [ACC_W-1:0]  sum_w;
    logic signed [ACC_W-1:0]  adj_w;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_full  = (fill_q == FILL_MAX);

    always_comb begin
        accept      = in_valid && in_ready && !clear;
        sum_w       = acc_q + ACC_W'($signed(in_data)) - ACC_W'($signed(dline_q[wp_q]));
        // Bias negative sums by N-1 so the arithmetic shift truncates toward zero.
        adj_w       = sum_w + (sum_w[ACC_W-1] ? RND : '0);
        wp_d        = wp_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            wp_d       = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
            acc_d      = sum_w;
            out_data_d = DATA_W'(adj_w >>> LOG2_N);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            if (FILL_MODE == 0 || fill_q >= FILL_LAST) begin
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                dline_q[i] <= '0;
            end
            wp_q        <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                dline_q[i] <= '0;
            end
            wp_q        <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                dline_q[wp_q] <= in_data;
            end
            wp_q        <= wp_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
